// File: rtl/risc8_pkg.sv
// Shared risc8 definitions: register-file geometry, transfer modes and the
// state encoding of the register transfer engine.
package risc8_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 6;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_TX       = 3'd3,
    ST_RX       = 3'd4,
    ST_WR       = 3'd5,
    ST_FIN      = 3'd6
  } state_t;

endpackage

// File: rtl/risc8_reg_xfer.sv
// Debug/context engine: dumps a block of byte registers onto a valid/ready
// stream, or loads a valid/ready byte stream into consecutive registers.
module risc8_reg_xfer #(
  parameter int NREGS  = risc8_pkg::NREGS,
  parameter int ADDR_W = risc8_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [$clog2(NREGS)-1:0] base,
  input  logic [$clog2(NREGS):0]   count,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        rf_a,
  input  logic [15:0]              rf_Ra,
  output logic                     rf_write,
  output logic                     rf_write_word,
  output logic [ADDR_W-1:0]        rf_d,
  output logic [15:0]              rf_Rd,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready
);
  import risc8_pkg::*;

  localparam int IDX_W = $clog2(NREGS);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W:0]     rem_reg, rem_next, rem_init;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               rf_write_reg, rf_write_next;
  logic               tx_valid_reg, tx_valid_next;
  logic               rx_ready_reg, rx_ready_next;
  logic [15:0]        rf_Rd_reg, rf_Rd_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic [ADDR_W-1:0]  rf_addr_reg;
  logic               last_beat;
  logic               rf_ra_hi_unused;

  // Only the low byte of the read port carries register data.
  assign rf_ra_hi_unused = ^rf_Ra[15:8];

  assign rem_init  = (count > (IDX_W+1)'(NREGS)) ? (IDX_W+1)'(NREGS) : count;
  assign last_beat = (rem_reg == (IDX_W+1)'(1));

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rem_next      = rem_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rf_write_next = 1'b0;
    rf_Rd_next    = rf_Rd_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    rx_ready_next = rx_ready_reg;

    if (state_reg != ST_IDLE && abort) begin
      state_next    = ST_IDLE;
      busy_next     = 1'b0;
      tx_valid_next = 1'b0;
      rx_ready_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            idx_next = base;
            rem_next = rem_init;
            if (rem_init == '0) begin
              state_next = ST_FIN;
              done_next  = 1'b1;
            end else begin
              busy_next = 1'b1;
              if (mode == MODE_LOAD) begin
                state_next    = ST_RX;
                rx_ready_next = 1'b1;
              end else begin
                state_next = ST_RD_ISSUE;
              end
            end
          end
        end
        // rf_a already holds idx here; the regfile registers it on this edge.
        ST_RD_ISSUE: state_next = ST_RD_CAPT;
        ST_RD_CAPT: begin
          tx_data_next  = rf_Ra[7:0];
          tx_valid_next = 1'b1;
          state_next    = ST_TX;
        end
        ST_TX: begin
          if (tx_ready) begin
            tx_valid_next = 1'b0;
            idx_next      = idx_reg + 1'b1;
            rem_next      = rem_reg - 1'b1;
            if (last_beat) begin
              state_next = ST_FIN;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end else begin
              state_next = ST_RD_ISSUE;
            end
          end
        end
        ST_RX: begin
          if (rx_valid) begin
            rx_ready_next = 1'b0;
            rf_Rd_next    = {8'h00, rx_data};
            rf_write_next = 1'b1;
            state_next    = ST_WR;
          end
        end
        ST_WR: begin
          idx_next = idx_reg + 1'b1;
          rem_next = rem_reg - 1'b1;
          if (last_beat) begin
            state_next = ST_FIN;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next    = ST_RX;
            rx_ready_next = 1'b1;
          end
        end
        ST_FIN:  state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      rem_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rf_write_reg <= 1'b0;
      rf_Rd_reg    <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      rx_ready_reg <= 1'b0;
      rf_addr_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      rem_reg      <= rem_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      rf_write_reg <= rf_write_next;
      rf_Rd_reg    <= rf_Rd_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      rx_ready_reg <= rx_ready_next;
      // Read and write address both follow the index one edge ahead of use.
      rf_addr_reg  <= ADDR_W'(idx_next);
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign rf_a          = rf_addr_reg;
  assign rf_d          = rf_addr_reg;
  assign rf_write      = rf_write_reg;
  assign rf_write_word = 1'b0;
  assign rf_Rd         = rf_Rd_reg;
  assign tx_data       = tx_data_reg;
  assign tx_valid      = tx_valid_reg;
  assign rx_ready      = rx_ready_reg;

endmodule

// File: tb/tb_risc8_reg_xfer.sv
// Bench for risc8_reg_xfer: regfile model, table of dump transfers, and
// hand-written load / abort / reset sequences checked through queues.
module tb_risc8_reg_xfer;

  logic        clk = 1'b0;
  logic        reset, start, mode, abort;
  logic [4:0]  base;
  logic [5:0]  count;
  logic        busy, done, rf_write, rf_write_word, tx_valid, tx_ready;
  logic        rx_valid, rx_ready;
  logic [5:0]  rf_a, rf_d;
  logic [15:0] rf_Ra, rf_Rd;
  logic [7:0]  tx_data, rx_data;

  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [7:0]  tb_wd;
  logic [7:0]  rf_mem [32];
  logic [7:0]  shadow [32];

  int n_pass = 0, n_total = 0;
  int cyc = 0, hs_count = 0, hs_cyc = 0, stall_cnt = 0, wr_count = 0;
  logic ready_rnd = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0]  txq [$];
  logic [21:0] wq [$];

  typedef struct {
    logic       mode;
    logic [4:0] base;
    logic [5:0] count;
    logic       rnd_ready;
    logic       poke;
    int         exp_n;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  risc8_reg_xfer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base),
    .count(count), .abort(abort), .busy(busy), .done(done), .rf_a(rf_a),
    .rf_Ra(rf_Ra), .rf_write(rf_write), .rf_write_word(rf_write_word),
    .rf_d(rf_d), .rf_Rd(rf_Rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  // Regfile model: registered read with write->read bypass.
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_d[4:0]] <= rf_Rd[7:0];
    else if (tb_we) rf_mem[tb_wa] <= tb_wd;
    rf_Ra <= (rf_write && rf_d == rf_a) ? rf_Rd : {8'h00, rf_mem[rf_a[4:0]]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = ready_rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // Stream and write monitor; inputs seen here are what the next edge samples.
  initial forever begin
    @(negedge clk);
    if (!reset) prev_stall = 1'b0;
    else begin
      if (tx_valid) begin
        if (prev_stall) check("tx_stable", 64'(tx_data), 64'(prev_data));
        if (tx_ready) begin
          if (txq.size() == 0) check("tx_extra_qsize", 64'(txq.size()), 64'(1));
          else check("tx_byte", 64'(tx_data), 64'(txq.pop_front()));
          hs_count++;
          hs_cyc = cyc;
        end else stall_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (rf_write) begin
        check("write_word", 64'(rf_write_word), 64'(0));
        if (wq.size() == 0) check("wr_extra_qsize", 64'(wq.size()), 64'(1));
        else check("wr_addr_data", 64'({rf_d, rf_Rd}), 64'(wq.pop_front()));
        wr_count++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 1000) begin @(posedge clk); #1; k++; end
    check(name, 64'(done), 64'(1));
  endtask

  task automatic run_xfer(input vec_t v);
    int hs0 = hs_count, st0 = stall_cnt;
    for (int i = 0; i < v.exp_n; i++) txq.push_back(shadow[(int'(v.base) + i) % 32]);
    ready_rnd = v.rnd_ready;
    @(posedge clk); #1;
    start = 1'b1; mode = v.mode; base = v.base; count = v.count;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(v.exp_n != 0));
    if (v.poke) begin
      @(posedge clk); #1; start = 1'b1; mode = 1'b1; count = 6'd1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done("done_seen");
    check("busy_at_done", 64'(busy), 64'(0));
    if (v.exp_n > 0) check("done_latency", 64'(cyc - hs_cyc), 64'(1));
    check("handshakes", 64'(hs_count - hs0), 64'(v.exp_n));
    check("txq_drained", 64'(txq.size()), 64'(0));
    if (v.rnd_ready) check("stalls_seen", 64'(stall_cnt > st0), 64'(1));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));
    $display("xfer dump base=%0d count=%0d bytes=%0d stalls=%0d",
             v.base, v.count, hs_count - hs0, stall_cnt - st0);
    ready_rnd = 1'b0;
    txq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k = 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b; rx_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!rx_ready && k < 50);
    check("rx_ready_seen", 64'(rx_ready), 64'(1));
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic start_xfer(input logic m, input logic [4:0] b, input logic [5:0] c);
    @(posedge clk); #1;
    start = 1'b1; mode = m; base = b; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [7:0] ld_bytes [3];

  initial begin
    int k, hs0, wr0;
    logic d_seen;
    reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; base = '0; count = '0;
    rx_valid = 1'b0; rx_data = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33;
    vecs[0] = '{1'b0, 5'd0,  6'd32, 1'b0, 1'b0, 32};
    vecs[1] = '{1'b0, 5'd30, 6'd4,  1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 5'd8,  6'd8,  1'b1, 1'b0, 8};
    vecs[3] = '{1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 0};
    vecs[4] = '{1'b0, 5'd3,  6'd40, 1'b0, 1'b0, 32};
    vecs[5] = '{1'b0, 5'd12, 6'd4,  1'b0, 1'b1, 4};

    repeat (3) @(posedge clk); #1;
    check("reset_ctrl", 64'({busy, done, rf_write, rf_write_word, tx_valid, rx_ready}), 64'(0));
    check("reset_data", 64'({rf_a, rf_d, rf_Rd, tx_data}), 64'(0));
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      tb_we = 1'b1; tb_wa = 5'(i); tb_wd = 8'(8'hA0 + i); shadow[i] = 8'(8'hA0 + i);
    end
    @(posedge clk); #1; tb_we = 1'b0;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // start together with abort in IDLE: nothing starts
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; count = 6'd4;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'({busy, done}), 64'(0));

    // LOAD base=5 count=3 with rx_valid gaps, then read back
    wr0 = wr_count;
    start_xfer(1'b1, 5'd5, 6'd3);
    for (int i = 0; i < 3; i++) begin
      wq.push_back({6'(5 + i), 8'h00, ld_bytes[i]});
      shadow[5 + i] = ld_bytes[i];
      send_byte(ld_bytes[i], i + 1);
    end
    wait_done("load_done");
    check("load_writes", 64'(wr_count - wr0), 64'(3));
    check("load_wq_drained", 64'(wq.size()), 64'(0));
    $display("xfer load base=5 count=3 writes=%0d", wr_count - wr0);
    run_xfer('{1'b0, 5'd5, 6'd3, 1'b0, 1'b0, 3});

    // abort after the second dump byte
    hs0 = hs_count;
    txq.push_back(shadow[0]); txq.push_back(shadow[1]);
    start_xfer(1'b0, 5'd0, 6'd8);
    k = 0;
    while (hs_count - hs0 < 2 && k < 200) begin @(posedge clk); k++; end
    #1 abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_tx_valid", 64'(tx_valid), 64'(0));
    d_seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; d_seen |= done; end
    check("abort_no_done", 64'(d_seen), 64'(0));
    check("abort_handshakes", 64'(hs_count - hs0), 64'(2));
    $display("xfer dump aborted after %0d bytes", hs_count - hs0);
    txq.delete();

    // reset while a load byte is about to be accepted
    start_xfer(1'b1, 5'd20, 6'd4);
    wq.push_back({6'd20, 8'h00, 8'h5A});
    shadow[20] = 8'h5A;
    send_byte(8'h5A, 0);
    rx_data = 8'h6B; rx_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!rx_ready && k < 50);
    reset = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("midload_reset_ctrl", 64'({busy, done, rf_write, rf_write_word, tx_valid, rx_ready}), 64'(0));
    check("midload_reset_data", 64'({rf_a, rf_d, rf_Rd, tx_data}), 64'(0));
    @(posedge clk); #1; reset = 1'b1;
    repeat (5) @(posedge clk);
    $display("xfer load reset mid-transfer, writes pending=%0d", wq.size());
    check("midload_wq_drained", 64'(wq.size()), 64'(0));
    run_xfer('{1'b0, 5'd20, 6'd2, 1'b0, 1'b0, 2});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
